// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel stream controller.
package sobel_pkg;

  localparam int LAT_DEF   = 3;
  localparam int DIM_W_DEF = 12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sobel_stream_ctrl_if.sv
// Pixel stream bundle between the byte source, the controller and the pixel sink.
// Handshake: an input byte transfers on a rising edge where s_valid && s_ready;
// m_valid has no ready and its m_data/m_last must be taken in that same cycle.
interface sobel_stream_ctrl_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;

  modport master (
    output s_valid, s_data,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/sobel_lat_pipe.sv
// Delays the filter enable and end-of-frame marker by exactly LAT cycles.
module sobel_lat_pipe #(
  parameter int LAT = sobel_pkg::LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_in,
  input  logic last_in,
  output logic valid_out,
  output logic last_out,
  output logic pending
);

  logic [LAT-1:0] valid_q, valid_d;
  logic [LAT-1:0] last_q, last_d;

  always_comb begin
    valid_d    = valid_q;
    last_d     = last_q;
    valid_d[0] = valid_in;
    last_d[0]  = valid_in && last_in;
    for (int i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      last_d[i]  = last_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign valid_out = valid_q[LAT-1];
  assign last_out  = last_q[LAT-1];
  // Any in-flight pixel keeps the frame in DRAIN.
  assign pending   = |valid_q;

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Frame controller feeding a fixed-latency Sobel_Filter from a byte stream.
// Optional build macro SOBEL_CTRL_PAD_EN: consume BMP 4-byte row padding.
module sobel_stream_ctrl
  import sobel_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIM_W-1:0]   img_width,
  input  logic [DIM_W-1:0]   img_height,
  sobel_stream_ctrl_if.slave strm,
  output logic               flt_en,
  output logic [31:0]        flt_data,
  input  logic [31:0]        flt_out,
  output logic               busy,
  output logic               done,
  output state_e             state_dbg
);

  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  state_e           state_q, state_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] wid_q, wid_d;
  logic [DIM_W-1:0] hgt_q, hgt_d;

  logic accept, pix_acc, last_col, last_row;
  logic pipe_pending;
  logic unused_flt_hi;

`ifdef SOBEL_CTRL_PAD_EN
  logic       in_pad_q, in_pad_d;
  logic [1:0] pad_cnt_q, pad_cnt_d;
  logic [1:0] pad_amt;

  // (4 - w mod 4) mod 4 is the two's complement of the low two width bits.
  assign pad_amt = 2'b00 - wid_q[1:0];
  assign pix_acc = accept && !in_pad_q;
`else
  assign pix_acc = accept;
`endif

  assign strm.s_ready = (state_q == S_RUN);
  assign accept       = strm.s_valid && strm.s_ready;
  assign last_col     = (col_q == wid_q - DIM_ONE);
  assign last_row     = (row_q == hgt_q - DIM_ONE);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    wid_d   = wid_q;
    hgt_d   = hgt_q;
`ifdef SOBEL_CTRL_PAD_EN
    in_pad_d  = in_pad_q;
    pad_cnt_d = pad_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          wid_d   = img_width;
          hgt_d   = img_height;
          col_d   = '0;
          row_d   = '0;
`ifdef SOBEL_CTRL_PAD_EN
          in_pad_d  = 1'b0;
          pad_cnt_d = 2'd0;
`endif
          state_d = (img_width != '0 && img_height != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (pix_acc) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + DIM_ONE;
`ifdef SOBEL_CTRL_PAD_EN
            if (pad_amt != 2'd0) begin
              in_pad_d  = 1'b1;
              pad_cnt_d = 2'd0;
            end else if (last_row) begin
              state_d = S_DRAIN;
            end
`else
            if (last_row) state_d = S_DRAIN;
`endif
          end else begin
            col_d = col_q + DIM_ONE;
          end
        end
`ifdef SOBEL_CTRL_PAD_EN
        // Row counter already points past the finished row while padding.
        if (accept && in_pad_q) begin
          if (pad_cnt_q == pad_amt - 2'd1) begin
            in_pad_d = 1'b0;
            if (row_q == hgt_q) state_d = S_DRAIN;
          end else begin
            pad_cnt_d = pad_cnt_q + 2'd1;
          end
        end
`endif
      end
      S_DRAIN: begin
        if (!pipe_pending) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      wid_q   <= '0;
      hgt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wid_q   <= wid_d;
      hgt_q   <= hgt_d;
    end
  end

`ifdef SOBEL_CTRL_PAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_pad_q  <= 1'b0;
      pad_cnt_q <= 2'd0;
    end else begin
      in_pad_q  <= in_pad_d;
      pad_cnt_q <= pad_cnt_d;
    end
  end
`endif

  sobel_lat_pipe #(.LAT(LAT)) u_lat_pipe (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (pix_acc),
    .last_in   (last_col && last_row),
    .valid_out (strm.m_valid),
    .last_out  (strm.m_last),
    .pending   (pipe_pending)
  );

  assign flt_en        = pix_acc;
  assign flt_data      = pix_acc ? {24'b0, strm.s_data} : 32'b0;
  assign strm.m_data   = flt_out[7:0];
  assign unused_flt_hi = ^flt_out[31:8];
  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign state_dbg     = state_q;

endmodule
